// File: rtl/gate_mux_selftest.sv
// Self-test sequencer for the MUX-based logic-gate block: walks a/b through all four
// input combinations, checks the seven gate outputs against their truth table and reports results.
module gate_mux_selftest #(
   parameter int HOLD_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a,
   output logic       b,
   input  logic       yand,
   input  logic       ynand,
   input  logic       yor,
   input  logic       ynor,
   input  logic       ynot,
   input  logic       yxor,
   input  logic       yxnor,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_count,
   output logic [6:0] fail_mask,
   output logic [3:0] fail_vec
);

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      DONE
   } state_t;

   localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

   state_t     state;
   state_t     state_next;
   logic [1:0] vec;
   logic [3:0] hold_cnt;
   logic       sample;
   logic [6:0] expected;
   logic [6:0] observed;
   logic [6:0] mismatch;
   logic [4:0] mism_pop;
   logic [4:0] err_next;

   // The vector counter is itself the registered a/b drive.
   assign a = vec[1];
   assign b = vec[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      sample     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = DRIVE;
            end
         end
         DRIVE: begin
            busy   = 1'b1;
            sample = (hold_cnt == HOLD_LAST);
            if (sample && (vec == 2'd3)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Bit order matches fail_mask: and, nand, or, nor, not, xor, xnor from bit 0 up.
   always_comb begin
      expected = {~(a ^ b), a ^ b, ~a, ~(a | b), a | b, ~(a & b), a & b};
      observed = {yxnor, yxor, ynot, ynor, yor, ynand, yand};
      mismatch = observed ^ expected;
      mism_pop = 5'd0;
      for (int i = 0; i < 7; i++) begin
         mism_pop = mism_pop + {4'd0, mismatch[i]};
      end
      err_next = err_count + mism_pop;
   end

   // Results clear only on an accepted start, so they stay readable after DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec       <= 2'd0;
         hold_cnt  <= 4'd0;
         pass      <= 1'b0;
         err_count <= 5'd0;
         fail_mask <= 7'd0;
         fail_vec  <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  vec       <= 2'd0;
                  hold_cnt  <= 4'd0;
                  pass      <= 1'b0;
                  err_count <= 5'd0;
                  fail_mask <= 7'd0;
                  fail_vec  <= 4'd0;
               end
            end
            DRIVE: begin
               if (sample) begin
                  hold_cnt       <= 4'd0;
                  err_count      <= err_next;
                  fail_mask      <= fail_mask | mismatch;
                  fail_vec[vec]  <= fail_vec[vec] | (mismatch != 7'd0);
                  if (vec == 2'd3) begin
                     vec  <= 2'd0;
                     pass <= (err_next == 5'd0);
                  end else begin
                     vec <= vec + 2'd1;
                  end
               end else begin
                  hold_cnt <= hold_cnt + 4'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_mux_selftest.sv
// Self-checking bench for gate_mux_selftest: a behavioural gate model with injectable faults
// feeds two sequencers (HOLD_CYCLES 2 and 1); expected run results go through a scoreboard queue.
module tb_gate_mux_selftest;

   typedef struct packed {
      logic [4:0] err;
      logic [6:0] mask;
      logic [3:0] fvec;
      logic       pass;
   } result_t;

   // Truth table per {a,b}, bits xnor,xor,not,nor,or,nand,and from MSB to LSB.
   localparam logic [6:0] TRUTH [4] = '{7'b1011010, 7'b0110110, 7'b0100110, 7'b1000101};

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start0;
   logic       start1;
   int         fault;
   logic       a0, b0, busy0, done0, pass0;
   logic [4:0] err0;
   logic [6:0] mask0;
   logic [3:0] fvec0;
   logic [6:0] y0;
   logic       a1, b1, busy1, done1, pass1;
   logic [4:0] err1;
   logic [6:0] mask1;
   logic [3:0] fvec1;
   logic [6:0] y1;
   int         compared = 0;
   int         mismatched = 0;
   result_t    sb0[$];
   result_t    sb1[$];

   always #5 clk = ~clk;

   function automatic logic [6:0] gateModel(logic [1:0] v, int f);
      logic [6:0] t;
      t = TRUTH[v];
      if (f == 1) t[5] = 1'b0;
      else if (f == 2) t = ~t;
      return t;
   endfunction

   function automatic result_t expectRun(int f);
      result_t    r;
      logic [6:0] m;
      r = '0;
      for (int v = 0; v < 4; v++) begin
         m = gateModel(2'(v), f) ^ TRUTH[v];
         r.err = r.err + 5'($countones(m));
         r.mask = r.mask | m;
         if (m != 7'd0) r.fvec[v] = 1'b1;
      end
      r.pass = (r.err == 5'd0);
      return r;
   endfunction

   assign y0 = gateModel({a0, b0}, fault);
   assign y1 = gateModel({a1, b1}, 0);

   gate_mux_selftest #(.HOLD_CYCLES(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0),
      .yand(y0[0]), .ynand(y0[1]), .yor(y0[2]), .ynor(y0[3]),
      .ynot(y0[4]), .yxor(y0[5]), .yxnor(y0[6]),
      .busy(busy0), .done(done0), .pass(pass0),
      .err_count(err0), .fail_mask(mask0), .fail_vec(fvec0)
   );

   gate_mux_selftest #(.HOLD_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
      .yand(y1[0]), .ynand(y1[1]), .yor(y1[2]), .ynor(y1[3]),
      .ynot(y1[4]), .yxor(y1[5]), .yxnor(y1[6]),
      .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .fail_mask(mask1), .fail_vec(fvec1)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One HOLD_CYCLES=2 run; cycle c is the cycle after start's accepting edge c-1.
   task automatic applyStimulus(input int f, input bit extraPulses);
      result_t r;
      @(negedge clk);
      fault  = f;
      start0 = 1'b1;
      sb0.push_back(expectRun(f));
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         start0 = extraPulses && (c == 3 || c == 9);
         checkOutput("busy", 32'(busy0), 32'(c <= 8));
         checkOutput("done", 32'(done0), 32'(c == 9));
         checkOutput("ab", 32'({a0, b0}), (c <= 8) ? 32'((c - 1) / 2) : 32'd0);
         if (done0) begin
            if (sb0.size() == 0) begin
               checkOutput("sb0_unexpected_done", 32'd1, 32'd0);
            end else begin
               r = sb0.pop_front();
               checkOutput("result", 32'({err0, mask0, fvec0, pass0}), 32'(r));
            end
         end
         if (c == 11) checkOutput("result_held", 32'({err0, mask0, fvec0, pass0}), 32'(expectRun(f)));
      end
      checkOutput("sb0_empty", 32'(sb0.size()), 32'd0);
   endtask

   initial begin
      result_t r;
      int      k;
      rst_n  = 1'b0;
      start0 = 1'b0;
      start1 = 1'b0;
      fault  = 0;
      repeat (3) @(negedge clk);
      checkOutput("reset_dut0", 32'({a0, b0, busy0, done0, pass0, err0, mask0, fvec0}), 32'd0);
      checkOutput("reset_dut1", 32'({a1, b1, busy1, done1, pass1, err1, mask1, fvec1}), 32'd0);
      rst_n = 1'b1;

      applyStimulus(0, 1'b0);
      checkOutput("pass_good", 32'(pass0), 32'd1);
      applyStimulus(1, 1'b0);
      checkOutput("xor_stuck_mask", 32'(mask0), 32'h20);
      applyStimulus(2, 1'b0);
      checkOutput("inverted_err", 32'(err0), 32'd28);
      applyStimulus(0, 1'b1);

      @(negedge clk);
      fault  = 0;
      start0 = 1'b1;
      for (int i = 0; i < 3; i++) sb0.push_back(expectRun(0));
      k = 0;
      for (int c = 1; c <= 32; c++) begin
         @(negedge clk);
         if (c == 29) start0 = 1'b0;
         if (done0) begin
            checkOutput("b2b_done_cycle", 32'(c), 32'(9 + 10 * k));
            k++;
            if (sb0.size() == 0) begin
               checkOutput("sb0_unexpected_done", 32'd1, 32'd0);
            end else begin
               r = sb0.pop_front();
               checkOutput("b2b_result", 32'({err0, mask0, fvec0, pass0}), 32'(r));
            end
         end
      end
      checkOutput("b2b_runs", 32'(k), 32'd3);
      checkOutput("sb0_empty_b2b", 32'(sb0.size()), 32'd0);

      @(negedge clk);
      fault  = 2;
      start0 = 1'b1;
      sb0.push_back(expectRun(2));
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start0 = 1'b0;
      end
      checkOutput("pre_abort_busy", 32'(busy0), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_clear", 32'({a0, b0, busy0, done0, pass0, err0, mask0, fvec0}), 32'd0);
      sb0.delete();
      k = 0;
      repeat (2) begin
         @(negedge clk);
         if (done0) k++;
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (done0) k++;
      end
      checkOutput("abort_no_done", 32'(k), 32'd0);
      applyStimulus(0, 1'b0);

      @(negedge clk);
      start1 = 1'b1;
      sb1.push_back(expectRun(0));
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         start1 = 1'b0;
         checkOutput("h1_busy", 32'(busy1), 32'(c <= 4));
         checkOutput("h1_done", 32'(done1), 32'(c == 5));
         checkOutput("h1_ab", 32'({a1, b1}), (c <= 4) ? 32'(c - 1) : 32'd0);
         if (done1) begin
            if (sb1.size() == 0) begin
               checkOutput("sb1_unexpected_done", 32'd1, 32'd0);
            end else begin
               r = sb1.pop_front();
               checkOutput("h1_result", 32'({err1, mask1, fvec1, pass1}), 32'(r));
            end
         end
      end
      checkOutput("sb1_empty", 32'(sb1.size()), 32'd0);
      checkOutput("h1_pass", 32'(pass1), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
